adc_spi_capture: RTL and testbench

//  4-channel simultaneous serial-ADC front end feeding the acquisition core. It paces conversions

---
 rtl/adc_capture_pkg.sv | 14 +
 rtl/adc_shift_lane.sv | 41 ++++
 rtl/adc_spi_capture.sv | 179 +++++++++++++++++
 tb/tb_adc_spi_capture.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared types for the 4-channel serial ADC front end.
// Holds the frame FSM encoding and the channel count.
package adc_capture_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_DONE
  } adc_state_e;

endpackage

// File: rtl/adc_shift_lane.sv
// adc_shift_lane: one channel's frame bit counter and sample shifter.
// Skips the leading zeros, keeps DATA_BITS bits MSB-first, ignores the rest.
module adc_shift_lane #(
  parameter int FRAME_BITS = 16,
  parameter int LEAD_ZEROS = 4,
  parameter int DATA_BITS  = 12
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 i_clr,
  input  logic                 i_stb,
  input  logic                 i_sdata,
  output logic [DATA_BITS-1:0] o_data
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] FIRST = CW'(LEAD_ZEROS);
  localparam logic [CW-1:0] LAST  = CW'(LEAD_ZEROS + DATA_BITS);

  logic [CW-1:0]        r_cnt;
  logic [DATA_BITS-1:0] r_sr;
  logic                 w_take;

  assign w_take = i_stb && (r_cnt >= FIRST) && (r_cnt < LAST);
  assign o_data = r_sr;

  // Count frame bits and shift in only the data window.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (i_stb) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_take) r_sr <= {r_sr[DATA_BITS-2:0], i_sdata};
    end
  end

endmodule

// File: rtl/adc_spi_capture.sv
// adc_spi_capture: paced 4-channel serial ADC capture with valid/ready out.
// ADC_TEST_PATTERN_EN replaces captured data with a per-frame counter.
module adc_spi_capture
  import adc_capture_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int FRAME_BITS  = 16,
  parameter int LEAD_ZEROS  = 4,
  parameter int DATA_BITS   = 12,
  parameter int CONV_PERIOD = 200
) (
  input  logic                        clk,
  input  logic                        reset_b,
  input  logic                        enable,
  input  logic [NUM_CH-1:0]           adc_sdata,
  output logic                        cs_n,
  output logic                        sclk,
  output logic [NUM_CH*DATA_BITS-1:0] sample_data,
  output logic                        sample_valid,
  input  logic                        sample_ready,
  output logic                        overrun,
  input  logic                        overrun_clr
);

  localparam int TW = $clog2(CONV_PERIOD);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int WW = NUM_CH * DATA_BITS;

  adc_state_e    r_state;
  logic [TW-1:0] r_timer;
  logic [DW-1:0] r_div;
  logic [BW-1:0] r_bit;
  logic          r_high;
  logic          r_load;

  logic          w_tick;
  logic          w_start;
  logic          w_div_end;
  logic          w_stb;
  logic          w_load_ok;
  logic [WW-1:0] w_frame;
  logic [WW-1:0] w_word;

  assign w_tick    = enable && (r_timer == TW'(CONV_PERIOD - 1));
  assign w_start   = (r_state == ST_IDLE) && w_tick;
  assign w_div_end = (r_div == DW'(CLK_DIV - 1));
  assign w_stb     = (r_state == ST_SHIFT) && !r_high && w_div_end;
  assign w_load_ok = r_load && (!sample_valid || sample_ready);

  // Conversion pacing: free-running period counter, parked at 0 when disabled.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_timer <= '0;
    end else if (!enable || w_tick) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Frame sequencer: drives cs_n/sclk and flags the output load.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= ST_IDLE;
      cs_n    <= 1'b1;
      sclk    <= 1'b1;
      r_div   <= '0;
      r_bit   <= '0;
      r_high  <= 1'b0;
      r_load  <= 1'b0;
    end else begin
      r_load <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_state <= ST_SETUP;
            cs_n    <= 1'b0;
            r_div   <= '0;
          end
        end
        ST_SETUP: begin
          if (w_div_end) begin
            r_state <= ST_SHIFT;
            r_div   <= '0;
            r_bit   <= '0;
            r_high  <= 1'b0;
            sclk    <= 1'b0;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!w_div_end) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (!r_high) begin
              r_high <= 1'b1;
              sclk   <= 1'b1;
            end else if (r_bit == BW'(FRAME_BITS - 1)) begin
              r_state <= ST_DONE;
              cs_n    <= 1'b1;
            end else begin
              r_bit  <= r_bit + 1'b1;
              r_high <= 1'b0;
              sclk   <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_load  <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    adc_shift_lane #(
      .FRAME_BITS (FRAME_BITS),
      .LEAD_ZEROS (LEAD_ZEROS),
      .DATA_BITS  (DATA_BITS)
    ) u_lane (
      .clk     (clk),
      .reset_b (reset_b),
      .i_clr   (w_start),
      .i_stb   (w_stb),
      .i_sdata (adc_sdata[g]),
      .o_data  (w_frame[g*DATA_BITS +: DATA_BITS])
    );
  end

`ifdef ADC_TEST_PATTERN_EN
  logic [DATA_BITS-1:0] r_pat;

  // Pattern counter advances once per delivered frame.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_pat <= '0;
    end else if (w_load_ok) begin
      r_pat <= r_pat + 1'b1;
    end
  end

  // Channel i carries count+i.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_word[i*DATA_BITS +: DATA_BITS] = r_pat + DATA_BITS'(i);
    end
  end
`else
  assign w_word = w_frame;
`endif

  // Output holding register with drop-on-full and sticky overrun.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (w_load_ok) begin
        sample_data  <= w_word;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (r_load && sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_capture.sv
// tb_adc_spi_capture: random ADC codes driven by serial ADC models,
// deliveries checked against codes queued for each conversion.
module tb_adc_spi_capture;

  localparam int CLK_DIV = 4;
  localparam int FB      = 16;
  localparam int LZ      = 4;
  localparam int DB      = 12;
  localparam int CP      = 200;
  localparam int NCH     = 4;
  localparam int W       = NCH * DB;
  localparam int LAT     = 2 + CLK_DIV * (1 + 2 * FB) + 1;

  logic         clk = 1'b0;
  logic         reset_b;
  logic         enable;
  logic [3:0]   adc_sdata;
  logic         cs_n;
  logic         sclk;
  logic [W-1:0] sample_data;
  logic         sample_valid;
  logic         sample_ready;
  logic         overrun;
  logic         overrun_clr;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int n_sclk = 0;
  int n_csf = 0;
  int adc_falls = 0;

  logic [W-1:0] adc_q[$];
  logic [W-1:0] got_q[$];
  int           acc_t[$];

  always #5 clk = ~clk;

  adc_spi_capture dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .enable       (enable),
    .adc_sdata    (adc_sdata),
    .cs_n         (cs_n),
    .sclk         (sclk),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(sclk) n_sclk <= n_sclk + 1;
  always @(negedge cs_n) n_csf <= n_csf + 1;

  always @(negedge clk) begin
    if (reset_b && sample_valid && sample_ready) begin
      got_q.push_back(sample_data);
      acc_t.push_back(cyc);
    end
  end

  function automatic logic adc_bit(input logic [DB-1:0] code, input int k);
    if (k < LZ) return 1'b0;
    if (k < LZ + DB) return code[DB-1-(k-LZ)];
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // Four ADCs sharing cs_n/sclk: next code per conversion, bit k after fall k.
  initial begin
    logic [W-1:0] cur;
    adc_sdata = '0;
    forever begin
      @(negedge cs_n);
      cur = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
      adc_falls = 0;
      adc_sdata = '0;
      while (cs_n === 1'b0) begin
        @(negedge sclk or posedge cs_n);
        if (cs_n === 1'b0) begin
          for (int i = 0; i < NCH; i++)
            adc_sdata[i] = adc_bit(cur[i*DB +: DB], adc_falls);
          adc_falls = adc_falls + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cs(output int c);
    int n;
    n = 0;
    while (cs_n === 1'b0 && n < 400) begin step(); n++; end
    while (cs_n !== 1'b0 && n < 1000) begin step(); n++; end
    check("cs_fall_seen", cs_n, 1'b0);
    c = cyc;
  endtask

  task automatic wait_valid(output int c);
    int n;
    n = 0;
    while (sample_valid !== 1'b1 && n < 400) begin step(); n++; end
    check("valid_seen", sample_valid, 1'b1);
    c = cyc;
  endtask

  task automatic wait_got(input int k, input int lim);
    int n;
    n = 0;
    while (got_q.size() < k && n < lim) begin step(); n++; end
  endtask

  task automatic t1_reset();
    int s0;
    repeat (3) step();
    s0 = n_sclk;
    repeat (300) step();
    check("rst_cs_n", cs_n, 1'b1);
    check("rst_sclk", sclk, 1'b1);
    check("rst_valid", sample_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_data", sample_data, '0);
    check("rst_sclk_edges", n_sclk - s0, 0);
  endtask

  task automatic t2_single();
    int c0, ccs, cv;
    logic [W-1:0] e;
    e = 48'h000_FFF_123_A5C;
    adc_q.push_back(e);
    enable = 1'b1;
    c0 = cyc;
    wait_cs(ccs);
    check("t2_start", ccs - c0, CP);
    wait_valid(cv);
    check("t2_latency", cv - (ccs - 1), LAT);
    check("t2_data", sample_data, e);
    check("t2_sclk_falls", adc_falls, FB);
  endtask

  task automatic t3_stream();
    int cx;
    logic [W-1:0] e3[5];
    sample_ready = 1'b1;
    wait_cs(cx);
    for (int i = 0; i < 5; i++) begin
      e3[i] = rnd_word();
      adc_q.push_back(e3[i]);
    end
    repeat (150) step();
    got_q.delete();
    acc_t.delete();
    wait_got(5, 1200);
    check("t3_count", got_q.size(), 5);
    if (got_q.size() == 5) begin
      for (int i = 0; i < 5; i++) check("t3_data", got_q[i], e3[i]);
      for (int i = 1; i < 5; i++)
        check("t3_spacing", acc_t[i] - acc_t[i-1], CP);
    end
    check("t3_overrun", overrun, 1'b0);
  endtask

  task automatic t4_overrun();
    int cx, ca, cb, cc, cv;
    logic [W-1:0] a, b, c;
    wait_cs(cx);
    a = rnd_word();
    b = rnd_word();
    c = rnd_word();
    adc_q.push_back(a);
    adc_q.push_back(b);
    adc_q.push_back(c);
    repeat (150) step();
    sample_ready = 1'b0;
    got_q.delete();
    wait_cs(ca);
    wait_valid(cv);
    check("t4_first", sample_data, a);
    wait_cs(cb);
    while (cyc < cb + 140) step();
    check("t4_overrun_set", overrun, 1'b1);
    check("t4_held", sample_data, a);
    check("t4_valid_held", sample_valid, 1'b1);
    wait_cs(cc);
    while (cyc < cc + 133) step();
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("t4_set_beats_clr", overrun, 1'b1);
    check("t4_held2", sample_data, a);
    repeat (5) step();
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("t4_clr", overrun, 1'b0);
    check("t4_none_taken", got_q.size(), 0);
    sample_ready = 1'b1;
    step();
    check("t4_taken", got_q.size(), 1);
    if (got_q.size() == 1) check("t4_taken_data", got_q[0], a);
  endtask

  task automatic t5_disable();
    int cx, cd, s;
    logic [W-1:0] d;
    wait_cs(cx);
    d = rnd_word();
    adc_q.push_back(d);
    repeat (150) step();
    got_q.delete();
    wait_cs(cd);
    while (cyc < cd + CLK_DIV + 8 * 2 * CLK_DIV) step();
    enable = 1'b0;
    repeat (200) step();
    check("t5_count", got_q.size(), 1);
    if (got_q.size() == 1) check("t5_data", got_q[0], d);
    check("t5_sclk_falls", adc_falls, FB);
    s = n_csf;
    repeat (1000) step();
    check("t5_no_start", n_csf - s, 0);
    check("t5_cs_idle", cs_n, 1'b1);
  endtask

  task automatic t6_reset_mid();
    int ce, cf, r0;
    logic [W-1:0] e, f;
    e = rnd_word();
    f = rnd_word();
    adc_q.push_back(e);
    adc_q.push_back(f);
    got_q.delete();
    enable = 1'b1;
    wait_cs(ce);
    while (cyc < ce + 40) step();
    #2 reset_b = 1'b0;
    #1;
    check("t6_async_cs_n", cs_n, 1'b1);
    check("t6_async_sclk", sclk, 1'b1);
    step();
    reset_b = 1'b1;
    r0 = cyc;
    got_q.delete();
    wait_cs(cf);
    check("t6_restart", cf - r0, CP);
    wait_got(1, 400);
    check("t6_count", got_q.size(), 1);
    if (got_q.size() == 1) check("t6_data", got_q[0], f);
  endtask

  task automatic t7_pattern();
    logic [W-1:0] w;
    sample_ready = 1'b1;
    got_q.delete();
    enable = 1'b1;
    wait_got(3, 1000);
    check("t7_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        w = got_q[i];
        check("t7_ch0", w[0*DB +: DB], i);
        check("t7_ch1", w[1*DB +: DB], i + 1);
        check("t7_ch2", w[2*DB +: DB], i + 2);
        check("t7_ch3", w[3*DB +: DB], i + 3);
      end
    end
  endtask

  initial begin
    reset_b = 1'b1;
    enable = 1'b0;
    sample_ready = 1'b0;
    overrun_clr = 1'b0;
    #3;
    reset_b = 1'b0;
    enable = 1'b1;
    t1_reset();
    enable = 1'b0;
    reset_b = 1'b1;
    step();
`ifdef ADC_TEST_PATTERN_EN
    t7_pattern();
`else
    t2_single();
    t3_stream();
    t4_overrun();
    t5_disable();
    t6_reset_mid();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
